// File: rtl/mul_div_hilo.sv
// mul_div_hilo: multiply/divide issue stage feeding an external multiplier, with HI/LO registers.
// Define MUL_DIV_HILO_DIV_EN to build the signed 32-cycle restoring divider; otherwise DIV reports op_err.
module mul_div_hilo #(
    parameter int MUL_WAIT = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic [63:0] mult_c,
    input  logic [1:0]  hilo_we,
    input  logic [31:0] hilo_wdata,
    output logic        busy,
    output logic        done,
    output logic        op_err,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MWAIT,
        S_MCAP,
        S_DPREP,
        S_DITER,
        S_DFIX,
        S_ERR
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [7:0] MUL_CNT = 8'(MUL_WAIT);

    state_t     state;
    logic [7:0] cnt;

`ifdef MUL_DIV_HILO_DIV_EN
    localparam logic [1:0] OP_DIV = 2'b01;

    logic [31:0] quo;    // dividend magnitude; quotient bits shift in from the bottom
    logic [31:0] dvs;
    logic [31:0] rem;
    logic        neg_q;
    logic        neg_r;
    logic [32:0] rem_sh;
    logic [32:0] diff;

    function automatic logic [31:0] mag(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

    // Trial subtraction; diff[32] set means the divisor did not fit this step.
    always_comb begin
        rem_sh = {rem, quo[31]};
        diff   = rem_sh - {1'b0, dvs};
    end
`endif

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mult_a <= '0;
            mult_b <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            op_err <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MUL_DIV_HILO_DIV_EN
            quo    <= '0;
            dvs    <= '0;
            rem    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            done   <= 1'b0;
            op_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= start;
                    if (start) begin
                        if (op == OP_MUL) begin
                            mult_a <= a_in;
                            mult_b <= b_in;
                            cnt    <= MUL_CNT;
                            state  <= S_MWAIT;
                        end
`ifdef MUL_DIV_HILO_DIV_EN
                        else if (op == OP_DIV && b_in != '0) begin
                            quo   <= a_in;
                            dvs   <= b_in;
                            neg_q <= a_in[31] ^ b_in[31];
                            neg_r <= a_in[31];
                            state <= S_DPREP;
                        end
`endif
                        else begin
                            state <= S_ERR;
                        end
                    end else begin
                        // MTHI/MTLO only land when no operation is being launched.
                        if (hilo_we[1]) hi <= hilo_wdata;
                        if (hilo_we[0]) lo <= hilo_wdata;
                    end
                end
                S_MWAIT: begin
                    if (cnt == 8'd1) state <= S_MCAP;
                    else             cnt   <= cnt - 8'd1;
                end
                S_MCAP: begin
                    {hi, lo} <= mult_c;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
`ifdef MUL_DIV_HILO_DIV_EN
                S_DPREP: begin
                    quo   <= mag(quo);
                    dvs   <= mag(dvs);
                    rem   <= '0;
                    cnt   <= 8'd32;
                    state <= S_DITER;
                end
                S_DITER: begin
                    if (diff[32]) begin
                        rem <= rem_sh[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end else begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) state <= S_DFIX;
                end
                S_DFIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend's sign.
                    lo    <= neg_q ? -quo : quo;
                    hi    <= neg_r ? -rem : rem;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
`endif
                S_ERR: begin
                    done   <= 1'b1;
                    op_err <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_hilo.sv
// Testbench for mul_div_hilo: table-driven operations through a scoreboard, plus hand-written
// abort and HI/LO write sequences. Expectations follow MUL_DIV_HILO_DIV_EN when it is defined.
module tb_mul_div_hilo;

`ifdef MUL_DIV_HILO_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int MUL_WAIT = 2;
    localparam int MUL_LAT  = MUL_WAIT + 1;
    localparam int DIV_LAT  = 34;
    localparam int TIMEOUT  = 100;
    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [31:0] mult_a, mult_b;
    logic [63:0] mult_c;
    logic [1:0]  hilo_we = 2'b00;
    logic [31:0] hilo_wdata = '0;
    logic        busy, done, op_err;
    logic [31:0] hi, lo;

    always #5 clock = ~clock;

    mul_div_hilo #(.MUL_WAIT(MUL_WAIT)) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .op         (op),
        .a_in       (a_in),
        .b_in       (b_in),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_c     (mult_c),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata),
        .busy       (busy),
        .done       (done),
        .op_err     (op_err),
        .hi         (hi),
        .lo         (lo)
    );

    // Behavioural stand-in for the combinational Booth multiplier.
    assign mult_c = {{32{mult_a[31]}}, mult_a} * {{32{mult_b[31]}}, mult_b};

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        keep;   // HI/LO expected to hold their previous values
        exp_t        e;
    } vec_t;

    localparam int NV = 13;
    vec_t tab [NV];
    exp_t sb [$];

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_ma = '0, m_mb = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input string name, input logic [31:0] h, input logic [31:0] l,
                                    input logic err, input int lat);
        exp_t e;
        e.name = name;
        e.hi   = h;
        e.lo   = l;
        e.err  = err;
        e.lat  = lat;
        return e;
    endfunction

    function automatic void set_vec(input int i, input string name, input logic [1:0] o,
                                    input logic [31:0] a, input logic [31:0] b, input logic keep,
                                    input logic [31:0] h, input logic [31:0] l, input logic err,
                                    input int lat);
        tab[i].op   = o;
        tab[i].a    = a;
        tab[i].b    = b;
        tab[i].keep = keep;
        tab[i].e    = mk_exp(name, h, l, err, lat);
    endfunction

    function automatic void div_row(input int i, input string name, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
        if (DIV_EN) set_vec(i, name, OP_DIV, a, b, 1'b0, h, l, 1'b0, DIV_LAT);
        else        set_vec(i, name, OP_DIV, a, b, 1'b1, 32'h0, 32'h0, 1'b1, 1);
    endfunction

    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output exp_t e, output logic keep);
        logic signed [63:0] sa, sd, r;
        sa   = {{32{a[31]}}, a};
        sd   = {{32{b[31]}}, b};
        keep = 1'b0;
        if (o == OP_MUL) begin
            r = sa * sd;
            e = mk_exp("rand_mul", r[63:32], r[31:0], 1'b0, MUL_LAT);
        end else if (o == OP_DIV && DIV_EN && b != 32'h0) begin
            e = mk_exp("rand_div", 32'(sa % sd), 32'(sa / sd), 1'b0, DIV_LAT);
        end else begin
            keep = 1'b1;
            e    = mk_exp("rand_err", 32'h0, 32'h0, 1'b1, 1);
        end
    endtask

    // Drive one operation, push its expectation, wait for done and score it.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic keep, input exp_t e_in, input bit b2b);
        exp_t e;
        int   n, gaps, err_early;
        e = e_in;
        if (keep) begin
            e.hi = m_hi;
            e.lo = m_lo;
        end else begin
            m_hi = e.hi;
            m_lo = e.lo;
        end
        if (o == OP_MUL) begin
            m_ma = a;
            m_mb = b;
        end
        sb.push_back(e);
        if (!b2b) @(negedge clock);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        n = 0;
        gaps = 0;
        err_early = 0;
        forever begin
            if (!busy) gaps++;
            if (!done && op_err) err_early++;
            if (done || n >= TIMEOUT) break;
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        e = sb.pop_front();
        check({e.name, "_latency"}, 64'(n), 64'(e.lat));
        check({e.name, "_busy_gaps"}, 64'(gaps), 64'd0);
        check({e.name, "_err_early"}, 64'(err_early), 64'd0);
        check({e.name, "_op_err"}, {63'd0, op_err}, {63'd0, e.err});
        check({e.name, "_hilo"}, {hi, lo}, {e.hi, e.lo});
        check({e.name, "_mult_ops"}, {mult_a, mult_b}, {m_ma, m_mb});
    endtask

    task automatic check_idle(input string name);
        @(negedge clock);
        check(name, {61'd0, busy, done, op_err}, 64'd0);
    endtask

    task automatic hilo_seq();
        @(negedge clock);
        hilo_we    = 2'b11;
        hilo_wdata = 32'hA5A5A5A5;
        @(negedge clock);
        hilo_we = 2'b00;
        m_hi = 32'hA5A5A5A5;
        m_lo = 32'hA5A5A5A5;
        check("hilo_write_both", {hi, lo}, {32'hA5A5A5A5, 32'hA5A5A5A5});
        // Write held across an accepted start and the following busy cycle must be dropped.
        hilo_we    = 2'b11;
        hilo_wdata = 32'h5A5A5A5A;
        run_op(2'b10, 32'h1, 32'h2, 1'b1, mk_exp("hilo_write_vs_start", 32'h0, 32'h0, 1'b1, 1), 1'b1);
        hilo_we = 2'b00;
        @(negedge clock);
        hilo_we    = 2'b10;
        hilo_wdata = 32'h12345678;
        @(negedge clock);
        hilo_we    = 2'b01;
        hilo_wdata = 32'h0BADF00D;
        check("hilo_write_hi_only", {hi, lo}, {32'h12345678, 32'hA5A5A5A5});
        @(negedge clock);
        hilo_we = 2'b00;
        check("hilo_write_lo_only", {hi, lo}, {32'h12345678, 32'h0BADF00D});
        m_hi = 32'h12345678;
        m_lo = 32'h0BADF00D;
    endtask

    task automatic abort_seq();
        logic [1:0] o1;
        int k_ign, k_rst, pulses;
        o1    = DIV_EN ? OP_DIV : OP_MUL;
        k_ign = DIV_EN ? 10 : 1;
        k_rst = DIV_EN ? 20 : 2;
        if (o1 == OP_MUL) begin
            m_ma = 32'd3;
            m_mb = 32'd5;
        end
        @(negedge clock);
        start = 1'b1;
        op    = o1;
        a_in  = 32'd3;
        b_in  = 32'd5;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int e = 1; e < k_rst; e++) begin
            if (e == k_ign) begin
                start = 1'b1;
                op    = OP_MUL;
                a_in  = 32'hDEAD0001;
                b_in  = 32'h2;
            end
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
            if (e == k_ign) begin
                check("abort_ignored_start_busy", {62'd0, busy, done}, 64'b10);
                check("abort_ignored_start_ops", {mult_a, mult_b}, {m_ma, m_mb});
            end
        end
        @(posedge clock);
        #2 clear = 1'b0;
        #1;
        check("abort_clear_hilo", {hi, lo}, 64'd0);
        check("abort_clear_ops", {mult_a, mult_b}, 64'd0);
        check("abort_clear_ctrl", {61'd0, busy, done, op_err}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        m_ma = '0;
        m_mb = '0;
        @(negedge clock);
        clear  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) pulses++;
        end
        check("abort_no_late_activity", 64'(pulses), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_vec(0,  "mul_7_x_m3",    OP_MUL, 32'h00000007, 32'hFFFFFFFD, 1'b0,
                32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MUL_LAT);
        set_vec(1,  "div_5_by_0",    OP_DIV, 32'h00000005, 32'h00000000, 1'b1,
                32'h0, 32'h0, 1'b1, 1);
        set_vec(2,  "mul_min_x_min", OP_MUL, 32'h80000000, 32'h80000000, 1'b0,
                32'h40000000, 32'h00000000, 1'b0, MUL_LAT);
        div_row(3,  "div_m7_by_2",   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        set_vec(4,  "mul_2p16_sq",   OP_MUL, 32'h00010000, 32'h00010000, 1'b0,
                32'h00000001, 32'h00000000, 1'b0, MUL_LAT);
        set_vec(5,  "op_10_resv",    2'b10,  32'h00000011, 32'h00000022, 1'b1,
                32'h0, 32'h0, 1'b1, 1);
        set_vec(6,  "mul_m1_x_m1",   OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
                32'h00000000, 32'h00000001, 1'b0, MUL_LAT);
        div_row(7,  "div_100_by_7",  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);
        set_vec(8,  "op_11_resv",    2'b11,  32'h00000033, 32'h00000044, 1'b1,
                32'h0, 32'h0, 1'b1, 1);
        div_row(9,  "div_min_by_m1", 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        div_row(10, "div_7_by_m2",   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        set_vec(11, "mul_x_zero",    OP_MUL, 32'h12345678, 32'h00000000, 1'b0,
                32'h00000000, 32'h00000000, 1'b0, MUL_LAT);
        div_row(12, "div_m100_by_7", 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2);

        repeat (2) @(negedge clock);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_ops", {mult_a, mult_b}, 64'd0);
        check("reset_ctrl", {61'd0, busy, done, op_err}, 64'd0);
        clear = 1'b1;

        for (int i = 0; i < NV; i++)
            run_op(tab[i].op, tab[i].a, tab[i].b, tab[i].keep, tab[i].e, 1'b0);
        check_idle("idle_after_table");

        // Random operations; odd iterations launch in the done cycle of the previous one.
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            exp_t        e;
            logic        keep;
            o = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 28);
            model(o, a, b, e, keep);
            run_op(o, a, b, keep, e, i[0]);
        end
        check_idle("idle_after_random");

        hilo_seq();
        abort_seq();
        run_op(OP_MUL, 32'd6, 32'd7, 1'b0, mk_exp("mul_after_abort", 32'h0, 32'd42, 1'b0, MUL_LAT), 1'b0);
        check_idle("idle_at_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
